// File: rtl/wb_sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_sdram_arbiter: round-robin, per-transfer Wishbone arbiter (CPU/DMA ->    |
// | SDRAM). Optional forced termination with macro ARB_TIMEOUT_EN. Rev 1.0      |
// +----------------------------------------------------------------------------+
module wb_sdram_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        cpu_stb_i,
  input  logic        cpu_cyc_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_dat_i,
  input  logic [31:0] cpu_adr_i,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_dat_o,
  input  logic        dma_stb_i,
  input  logic        dma_cyc_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_sel_i,
  input  logic [31:0] dma_dat_i,
  input  logic [31:0] dma_adr_i,
  output logic        dma_ack_o,
  output logic [31:0] dma_dat_o,
  output logic        sdr_stb_o,
  output logic        sdr_cyc_o,
  output logic        sdr_we_o,
  output logic [3:0]  sdr_sel_o,
  output logic [31:0] sdr_dat_o,
  output logic [31:0] sdr_adr_o,
  input  logic        sdr_ack_i,
  input  logic [31:0] sdr_dat_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_cpu_q, last_cpu_d;   // 1: CPU was granted most recently
  logic   cpu_req, dma_req;
  logic   own_cpu, own_dma;
  logic   to_fire;

  assign cpu_req = cpu_cyc_i & cpu_stb_i;
  assign dma_req = dma_cyc_i & dma_stb_i;
  assign own_cpu = (state_q == OWN_CPU);
  assign own_dma = (state_q == OWN_DMA);

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q;

  // A real ack at the limit wins; an abandoned transfer is not terminated.
  assign to_fire = ((own_cpu & cpu_cyc_i) | (own_dma & dma_cyc_i)) & ~sdr_ack_i &
                   (to_cnt_q == TO_W'(TIMEOUT));
  assign timeout_o = timeout_q;
`else
  assign to_fire   = 1'b0;
  // Parameters only matter when the counter is built.
  assign timeout_o = 1'b0 & (TO_W > 0) & (TIMEOUT >= 0);
`endif

  always_comb begin
    state_d    = state_q;
    last_cpu_d = last_cpu_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && (!dma_req || !last_cpu_q)) begin
          state_d    = OWN_CPU;
          last_cpu_d = 1'b1;
        end else if (dma_req) begin
          state_d    = OWN_DMA;
          last_cpu_d = 1'b0;
        end
      end
      OWN_CPU: begin
        if (sdr_ack_i) begin
          if (dma_req) begin
            state_d    = OWN_DMA;
            last_cpu_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (!cpu_cyc_i || to_fire) begin
          state_d = IDLE;
        end
      end
      OWN_DMA: begin
        if (sdr_ack_i) begin
          if (cpu_req) begin
            state_d    = OWN_CPU;
            last_cpu_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!dma_cyc_i || to_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  // Staying in an owned state implies no ack this cycle, so any change clears.
  assign to_cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : to_cnt_q + 1'b1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (to_fire) timeout_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      last_cpu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_cpu_q <= last_cpu_d;
    end
  end

  always_comb begin
    sdr_cyc_o = 1'b0;
    sdr_stb_o = 1'b0;
    sdr_we_o  = 1'b0;
    sdr_sel_o = '0;
    sdr_dat_o = '0;
    sdr_adr_o = '0;
    cpu_ack_o = 1'b0;
    cpu_dat_o = '0;
    dma_ack_o = 1'b0;
    dma_dat_o = '0;
    if (own_cpu) begin
      sdr_cyc_o = cpu_cyc_i & ~to_fire;
      sdr_stb_o = cpu_stb_i & ~to_fire;
      sdr_we_o  = cpu_we_i;
      sdr_sel_o = cpu_sel_i;
      sdr_dat_o = cpu_dat_i;
      sdr_adr_o = cpu_adr_i;
      cpu_ack_o = sdr_ack_i | to_fire;
      cpu_dat_o = to_fire ? 32'hDEAD_BEEF : sdr_dat_i;
    end else if (own_dma) begin
      sdr_cyc_o = dma_cyc_i & ~to_fire;
      sdr_stb_o = dma_stb_i & ~to_fire;
      sdr_we_o  = dma_we_i;
      sdr_sel_o = dma_sel_i;
      sdr_dat_o = dma_dat_i;
      sdr_adr_o = dma_adr_i;
      dma_ack_o = sdr_ack_i | to_fire;
      dma_dat_o = to_fire ? 32'hDEAD_BEEF : sdr_dat_i;
    end
  end

endmodule
`default_nettype wire
